// File: rtl/gold_nic.sv
// gold_nic: single-slot receive/transmit network interface card.
// Define NIC_IRQ_EN to add the receive interrupt (irq port, irq_en register).
module gold_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
`ifdef NIC_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [1:0] IN_DATA  = 2'b00;
    localparam logic [1:0] IN_STAT  = 2'b01;
    localparam logic [1:0] OUT_DATA = 2'b10;
    localparam logic [1:0] OUT_STAT = 2'b11;

    logic [63:0] in_buf;
    logic        in_full;
    logic [63:0] out_buf;
    logic        out_full;

    logic        rd;
    logic        wr;
    logic        rx_take;
    logic        rx_pop;
    logic        tx_load;
    logic [63:0] rd_val;
    logic [63:0] in_stat;

    assign rd = nicEn & ~nicWrEn;
    assign wr = nicEn & nicWrEn;

    assign net_ri = ~in_full & ~reset;
    assign net_do = out_buf;

    // Bit 63 of the packet selects the VC; send only on the matching phase.
    assign net_so = out_full & net_ro & ~reset
                  & (net_polarity == out_buf[63]);

    assign rx_take = net_si & net_ri;
    assign rx_pop  = rd & (addr == IN_DATA) & in_full;
    assign tx_load = wr & (addr == OUT_DATA) & ~out_full;

`ifdef NIC_IRQ_EN
    logic irq_en;
    logic en_wr;

    assign en_wr   = wr & (addr == IN_STAT);
    assign in_stat = {62'b0, irq_en, in_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (en_wr)
                irq_en <= d_in[0];
            if (rx_pop || (en_wr && !d_in[0]))
                irq <= 1'b0;
            else if (in_full && irq_en)
                irq <= 1'b1;
        end
    end
`else
    assign in_stat = {63'b0, in_full};
`endif

    always_comb begin
        rd_val = 64'b0;
        unique case (addr)
            IN_DATA:  rd_val = in_buf;
            IN_STAT:  rd_val = in_stat;
            OUT_DATA: rd_val = 64'b0;
            OUT_STAT: rd_val = {63'b0, out_full};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf   <= 64'b0;
            in_full  <= 1'b0;
            out_buf  <= 64'b0;
            out_full <= 1'b0;
            d_out    <= 64'b0;
        end else begin
            // A take needs an empty slot and a pop a full one, so they never overlap.
            if (rx_take) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (rx_pop) begin
                in_full <= 1'b0;
            end
            if (tx_load) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end else if (net_so) begin
                out_full <= 1'b0;
            end
            d_out <= rd ? rd_val : 64'b0;
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Self-checking bench for gold_nic: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_gold_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;
`ifdef NIC_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    gold_nic dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .d_in(d_in),
        .d_out(d_out),
        .nicEn(nicEn),
        .nicWrEn(nicWrEn),
        .net_si(net_si),
        .net_ri(net_ri),
        .net_di(net_di),
        .net_so(net_so),
        .net_ro(net_ro),
        .net_do(net_do),
        .net_polarity(net_polarity)
`ifdef NIC_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic        en;
        logic        wr;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic        e_ri;
        logic        e_so;
        logic [63:0] e_do;
        logic [63:0] e_dout;
    } vec_t;

    localparam logic [63:0] PK1 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] PK3 = 64'h8000_0000_0000_0003;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic en,
                         input logic wr, input logic [63:0] din,
                         input logic si, input logic [63:0] di,
                         input logic ro, input logic pol);
        addr = a;
        nicEn = en;
        nicWrEn = wr;
        d_in = din;
        net_si = si;
        net_di = di;
        net_ro = ro;
        net_polarity = pol;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [1:0] a, input logic en, input logic wr,
        input logic [63:0] din, input logic si, input logic [63:0] di,
        input logic ro, input logic pol, input logic e_ri,
        input logic e_so, input logic [63:0] e_do,
        input logic [63:0] e_dout);
        vec_t v;
        v.a = a; v.en = en; v.wr = wr; v.din = din;
        v.si = si; v.di = di; v.ro = ro; v.pol = pol;
        v.e_ri = e_ri; v.e_so = e_so;
        v.e_do = e_do; v.e_dout = e_dout;
        return v;
    endfunction

    vec_t tbl[13];

    // Reference model: one-deep queues per direction plus last-seen buffers.
    logic [63:0] rxq[$];
    logic [63:0] txq[$];
    logic [63:0] last_rx;
    logic [63:0] last_tx;
    logic        m_irq_en;
    logic        m_irq;

    initial begin
        logic        r_rst;
        logic [1:0]  a;
        logic        en, wr, si, ro, pol;
        logic [63:0] din, di, rv, e_dout;
        logic        e_ri, e_so, pop, tx_empty, w01;

        reset = 1'b1;
        idle();
        edge_wait();
        edge_wait();
        @(negedge clk);
        chk("reset ri", {63'b0, net_ri}, 64'd0);
        chk("reset so", {63'b0, net_so}, 64'd0);
        chk("reset dout", d_out, 64'd0);
        chk("reset do", net_do, 64'd0);
        edge_wait();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset ri", {63'b0, net_ri}, 64'd1);
        edge_wait();

        // receive, status, send with polarity, drop while full
        tbl[0]  = mk(2'd0, 0, 0, 64'd0, 1, 64'hA5, 0, 0, 1, 0, 64'd0, 64'd0);
        tbl[1]  = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 64'd0, 64'd1);
        tbl[2]  = mk(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 64'd0, 64'hA5);
        tbl[3]  = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 1, 0, 64'd0, 64'd0);
        tbl[4]  = mk(2'd2, 1, 1, PK1, 0, 64'd0, 1, 0, 1, 0, 64'd0, 64'd0);
        tbl[5]  = mk(2'd2, 1, 1, 64'd2, 0, 64'd0, 0, 0, 1, 0, PK1, 64'd0);
        tbl[6]  = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 0, 1, 0, PK1, 64'd1);
        tbl[7]  = mk(2'd0, 0, 0, 64'd0, 0, 64'd0, 1, 1, 1, 1, PK1, 64'd0);
        tbl[8]  = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1, 1, 0, PK1, 64'd0);
        tbl[9]  = mk(2'd2, 1, 1, PK3, 0, 64'd0, 0, 0, 1, 0, PK1, 64'd0);
        tbl[10] = mk(2'd2, 1, 1, 64'd5, 0, 64'd0, 1, 1, 1, 1, PK3, 64'd0);
        tbl[11] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1, 1, 0, PK3, 64'd0);
        tbl[12] = mk(2'd2, 1, 0, 64'd0, 0, 64'd0, 0, 0, 1, 0, PK3, 64'd0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].a, tbl[i].en, tbl[i].wr, tbl[i].din,
                  tbl[i].si, tbl[i].di, tbl[i].ro, tbl[i].pol);
            @(negedge clk);
            chk($sformatf("vec%0d ri", i), {63'b0, net_ri}, {63'b0, tbl[i].e_ri});
            chk($sformatf("vec%0d so", i), {63'b0, net_so}, {63'b0, tbl[i].e_so});
            chk($sformatf("vec%0d do", i), net_do, tbl[i].e_do);
            edge_wait();
            chk($sformatf("vec%0d dout", i), d_out, tbl[i].e_dout);
        end

        // back-pressure: second packet held off for five cycles
        drive(2'd0, 0, 0, 64'd0, 1, 64'h1234, 0, 0);
        @(negedge clk);
        chk("bp load ri", {63'b0, net_ri}, 64'd1);
        edge_wait();
        for (int i = 0; i < 5; i++) begin
            drive(2'd0, 0, 0, 64'd0, 1, 64'hFFFF_0000_FFFF_0000, 0, 0);
            @(negedge clk);
            chk($sformatf("bp%0d ri", i), {63'b0, net_ri}, 64'd0);
            edge_wait();
        end
        drive(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0);
        @(negedge clk);
        chk("bp read ri", {63'b0, net_ri}, 64'd0);
        edge_wait();
        chk("bp read dout", d_out, 64'h1234);
        drive(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0);
        @(negedge clk);
        chk("stale ri", {63'b0, net_ri}, 64'd1);
        edge_wait();
        chk("stale dout", d_out, 64'h1234);
        idle();
        @(negedge clk);
        chk("stale after ri", {63'b0, net_ri}, 64'd1);
        edge_wait();

        // reset mid-send discards both buffers
        drive(2'd2, 1, 1, 64'h8000_0000_0000_0009, 1, 64'h77, 0, 0);
        edge_wait();
        reset = 1'b1;
        drive(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1);
        @(negedge clk);
        chk("rst so", {63'b0, net_so}, 64'd0);
        chk("rst ri", {63'b0, net_ri}, 64'd0);
        edge_wait();
        chk("rst dout", d_out, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst rel so", {63'b0, net_so}, 64'd0);
        chk("rst rel ri", {63'b0, net_ri}, 64'd1);
        edge_wait();
        chk("rst rel out stat", d_out, 64'd0);

`ifdef NIC_IRQ_EN
        drive(2'd1, 1, 1, 64'd1, 0, 64'd0, 0, 0);
        edge_wait();
        drive(2'd0, 0, 0, 64'd0, 1, 64'h7, 0, 0);
        edge_wait();
        drive(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0);
        @(negedge clk);
        chk("irq not yet", {63'b0, irq}, 64'd0);
        edge_wait();
        chk("irq stat", d_out, 64'd3);
        drive(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0);
        @(negedge clk);
        chk("irq set", {63'b0, irq}, 64'd1);
        edge_wait();
        chk("irq cleared", {63'b0, irq}, 64'd0);
        chk("irq data", d_out, 64'h7);
`endif

        // sync model with a reset, then random traffic
        reset = 1'b1;
        idle();
        edge_wait();
        reset = 1'b0;
        rxq.delete();
        txq.delete();
        last_rx = 64'd0;
        last_tx = 64'd0;
        m_irq_en = 1'b0;
        m_irq = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            a = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 2) != 0);
            wr = 1'($urandom_range(0, 1));
            din = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                din[63:1] = 63'd0;
            si = 1'($urandom_range(0, 1));
            di = {$urandom, $urandom};
            ro = 1'($urandom_range(0, 1));
            pol = 1'($urandom_range(0, 1));

            e_ri = !r_rst && (rxq.size() == 0);
            e_so = !r_rst && (txq.size() != 0) && ro
                   && (pol == txq[0][63]);

            reset = r_rst;
            drive(a, en, wr, din, si, di, ro, pol);
            @(negedge clk);
            chk("rnd ri", {63'b0, net_ri}, {63'b0, e_ri});
            chk("rnd so", {63'b0, net_so}, {63'b0, e_so});
            chk("rnd do", net_do, last_tx);
`ifdef NIC_IRQ_EN
            chk("rnd irq", {63'b0, irq}, {63'b0, m_irq});
`endif

            if (r_rst) begin
                rxq.delete();
                txq.delete();
                last_rx = 64'd0;
                last_tx = 64'd0;
                m_irq_en = 1'b0;
                m_irq = 1'b0;
                e_dout = 64'd0;
            end else begin
                case (a)
                    2'd0: rv = last_rx;
`ifdef NIC_IRQ_EN
                    2'd1: rv = {62'd0, m_irq_en, rxq.size() != 0};
`else
                    2'd1: rv = {63'd0, rxq.size() != 0};
`endif
                    2'd2: rv = 64'd0;
                    default: rv = {63'd0, txq.size() != 0};
                endcase
                e_dout = (en && !wr) ? rv : 64'd0;
                pop = en && !wr && (a == 2'd0) && (rxq.size() != 0);
                w01 = en && wr && (a == 2'd1);
`ifdef NIC_IRQ_EN
                if (pop || (w01 && !din[0]))
                    m_irq = 1'b0;
                else if (rxq.size() != 0 && m_irq_en)
                    m_irq = 1'b1;
                if (w01)
                    m_irq_en = din[0];
`else
                if (w01)
                    rv = 64'd0;
`endif
                tx_empty = (txq.size() == 0);
                if (e_so)
                    void'(txq.pop_front());
                if (en && wr && (a == 2'd2) && tx_empty) begin
                    txq.push_back(din);
                    last_tx = din;
                end
                if (pop)
                    void'(rxq.pop_front());
                if (si && e_ri) begin
                    rxq.push_back(di);
                    last_rx = di;
                end
            end
            edge_wait();
            chk("rnd dout", d_out, e_dout);
        end

        reset = 1'b0;
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
